// File: rtl/i2c_slave.sv
// I2C responder: 7-bit addressed slave with byte write to data_out and
// byte read from data_in. sclk/sda are oversampled on clk through 2-flop
// synchronizers; all bus events are derived from edges of the synced copies.
`timescale 1ns/1ps

module i2c_slave #(
  parameter logic [6:0] I2C_SLAVE_ADDRESS = 7'h5a
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [3:0] state
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WRITE     = 4'd3,
    WRITE_ACK = 4'd4,
    READ      = 4'd5,
    READ_ACK  = 4'd6,
    WAIT_STOP = 4'd7
  } state_t;

  // Synchronizer and edge-history flops
  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_sda_meta,  r_sda_sync,  r_sda_prev;

  // Protocol state
  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DATA_W-1:0]  r_tx_shift;
  logic               r_sda_out;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_data_valid;
  logic               r_byte_done;

  // Next-state values
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [DATA_W-1:0]  w_rx_shift_nxt;
  logic [DATA_W-1:0]  w_tx_shift_nxt;
  logic               w_sda_out_nxt;
  logic [DATA_W-1:0]  w_data_out_nxt;
  logic               w_data_valid_nxt;
  logic               w_byte_done_nxt;

  // Bus events
  logic               w_sclk_rise;
  logic               w_sclk_fall;
  logic               w_sda_rise;
  logic               w_sda_fall;
  logic               w_start;
  logic               w_stop;
  logic               w_last_bit;
  logic [DATA_W-1:0]  w_rx_byte;

  // Two-flop synchronizers plus one history flop; idle bus level is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_meta <= 1'b1;
      r_sclk_sync <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_sda_meta  <= 1'b1;
      r_sda_sync  <= 1'b1;
      r_sda_prev  <= 1'b1;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_sda_meta  <= sda_in;
      r_sda_sync  <= r_sda_meta;
      r_sda_prev  <= r_sda_sync;
    end
  end

  // Edge and START/STOP decode on the synchronized bus
  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
  assign w_sda_rise  = r_sda_sync & ~r_sda_prev;
  assign w_sda_fall  = ~r_sda_sync & r_sda_prev;
  assign w_start     = w_sda_fall & r_sclk_sync;
  assign w_stop      = w_sda_rise & r_sclk_sync;
  assign w_last_bit  = (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_rx_byte   = {r_rx_shift[DATA_W-2:0], r_sda_sync};

  // State and datapath register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_sda_out    <= 1'b1;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_byte_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_sda_out    <= w_sda_out_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_byte_done  <= w_byte_done_nxt;
    end
  end

  // Next-state and datapath logic; START/STOP outrank any sclk edge
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_rx_shift_nxt   = r_rx_shift;
    w_tx_shift_nxt   = r_tx_shift;
    w_sda_out_nxt    = r_sda_out;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_byte_done_nxt  = r_byte_done;

    if (w_start) begin
      w_state_nxt     = ADDR;
      w_bit_cnt_nxt   = '0;
      w_rx_shift_nxt  = '0;
      w_sda_out_nxt   = 1'b1;
      w_byte_done_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt     = IDLE;
      w_bit_cnt_nxt   = '0;
      w_sda_out_nxt   = 1'b1;
      w_byte_done_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_sda_out_nxt = 1'b1;
        end

        // Shift address byte; ACK on the falling edge after the 8th bit
        ADDR: begin
          if (w_sclk_rise && !r_byte_done) begin
            w_rx_shift_nxt = w_rx_byte;
            w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              if (w_rx_byte[DATA_W-1:1] == I2C_SLAVE_ADDRESS) begin
                w_byte_done_nxt = 1'b1;
              end else begin
                w_state_nxt   = IDLE;
                w_sda_out_nxt = 1'b1;
              end
            end
          end else if (w_sclk_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_sda_out_nxt   = 1'b0;
            w_state_nxt     = ADDR_ACK;
          end
        end

        // ACK held through the 9th clock; its falling edge picks direction
        ADDR_ACK: begin
          if (w_sclk_fall) begin
            w_bit_cnt_nxt = '0;
            if (r_rx_shift[0]) begin
              w_tx_shift_nxt = data_in;
              w_sda_out_nxt  = data_in[DATA_W-1];
              w_state_nxt    = READ;
            end else begin
              w_sda_out_nxt  = 1'b1;
              w_state_nxt    = WRITE;
            end
          end
        end

        // Shift a data byte; publish it on the 8th rising edge
        WRITE: begin
          if (w_sclk_rise && !r_byte_done) begin
            w_rx_shift_nxt = w_rx_byte;
            w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_data_out_nxt   = w_rx_byte;
              w_data_valid_nxt = 1'b1;
              w_byte_done_nxt  = 1'b1;
            end
          end else if (w_sclk_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_sda_out_nxt   = 1'b0;
            w_state_nxt     = WRITE_ACK;
          end
        end

        // End of ACK clock: release and expect another byte
        WRITE_ACK: begin
          if (w_sclk_fall) begin
            w_sda_out_nxt = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = WRITE;
          end
        end

        // Drive the next tx bit after each falling edge; release after bit 0
        READ: begin
          if (w_sclk_fall) begin
            if (w_last_bit) begin
              w_sda_out_nxt = 1'b1;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = READ_ACK;
            end else begin
              w_sda_out_nxt  = r_tx_shift[DATA_W-2];
              w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
              w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        // Master ACK reloads the next byte; NACK parks until STOP/START
        READ_ACK: begin
          if (w_sclk_rise) begin
            if (r_sda_sync) begin
              w_sda_out_nxt = 1'b1;
              w_state_nxt   = WAIT_STOP;
            end
          end else if (w_sclk_fall) begin
            w_tx_shift_nxt = data_in;
            w_sda_out_nxt  = data_in[DATA_W-1];
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = READ;
          end
        end

        WAIT_STOP: begin
          w_sda_out_nxt = 1'b1;
        end

        default: begin
          w_state_nxt   = IDLE;
          w_sda_out_nxt = 1'b1;
        end
      endcase
    end
  end

  assign sda_out    = r_sda_out;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign state      = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master with scoreboard queues for the
// expected sda_out level on every sclk-high phase and for received bytes.
`timescale 1ns/1ps

module tb_i2c_slave;

  localparam time Q = 40ns;  // quarter sclk period (4 clk)

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] state;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_dv  = 0;
  logic       dv_prev = 1'b0;
  logic       q_sda[$];
  logic [7:0] q_byte[$];
  logic [7:0] exp_b;

  i2c_slave #(.I2C_SLAVE_ADDRESS(7'h5a)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .sda_in     (sda_in),
    .sda_out    (sda_out),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Received-byte scoreboard: every data_valid pulse must match a queued byte
  always @(negedge clk) begin
    if (data_valid) begin
      n_dv++;
      n_vec++;
      if (q_byte.size() == 0) begin
        n_err++;
        $display("FAIL dv_unexpected: data_valid with data_out=%h, none expected", data_out);
      end else begin
        exp_b = q_byte.pop_front();
        if (data_out !== exp_b) begin
          n_err++;
          $display("FAIL rx_byte: data_out=%h expected %h", data_out, exp_b);
        end
      end
      if (dv_prev) begin
        n_err++;
        $display("FAIL dv_width: data_valid high for more than one clk");
      end
    end
    dv_prev = data_valid;
  end

  // One sclk period; sda_out seen in the high phase is checked against the queue
  task automatic sclk_bit(input logic b, input string tag);
    logic exp;
    sda_in = b;
    #Q; sclk = 1'b1;
    #Q;
    n_vec++;
    if (q_sda.size() == 0) begin
      n_err++;
      $display("FAIL %s: sda_out=%b with no expectation queued", tag, sda_out);
    end else begin
      exp = q_sda.pop_front();
      if (sda_out !== exp) begin
        n_err++;
        $display("FAIL %s: sda_out=%b expected %b", tag, sda_out, exp);
      end
    end
    #Q; sclk = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    if (sclk == 1'b0) begin
      sda_in = 1'b1;
      #Q; sclk = 1'b1;
      #Q;
    end
    sda_in = 1'b0;
    #Q; sclk = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_in = 1'b0;
    #Q; sclk = 1'b1;
    #Q; sda_in = 1'b1;
    #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    for (int i = 7; i >= 0; i--) begin
      q_sda.push_back(1'b1);
      sclk_bit(b[i], tag);
    end
    q_sda.push_back(exp_ack);
    sclk_bit(1'b1, {tag, "_ack"});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string tag);
    for (int i = 7; i >= 0; i--) begin
      q_sda.push_back(exp[i]);
      sclk_bit(1'b1, tag);
    end
    q_sda.push_back(1'b1);
    sclk_bit(m_ack, {tag, "_ackslot"});
  endtask

  task automatic check_state(input logic [3:0] exp, input string tag);
    n_vec++;
    if (state !== exp) begin
      n_err++;
      $display("FAIL %s: state=%0d expected %0d", tag, state, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sclk = 1'b1; sda_in = 1'b1; data_in = 8'h00;
    #50;
    n_vec++; if (sda_out !== 1'b1)     begin n_err++; $display("FAIL rst_sda: sda_out=%b expected 1", sda_out); end
    n_vec++; if (data_out !== 8'h00)   begin n_err++; $display("FAIL rst_data: data_out=%h expected 00", data_out); end
    n_vec++; if (data_valid !== 1'b0)  begin n_err++; $display("FAIL rst_dv: data_valid=%b expected 0", data_valid); end
    check_state(4'd0, "rst_state");
    @(negedge clk); rst = 1'b1;
    #100;
  endtask

  task automatic test_write();
    int dv0 = n_dv;
    i2c_start();
    check_state(4'd1, "wr_after_start");
    write_byte(8'hB4, 1'b0, "wr_addr");
    q_byte.push_back(8'hC3);
    write_byte(8'hC3, 1'b0, "wr_data");
    i2c_stop();
    check_state(4'd0, "wr_after_stop");
    n_vec++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL wr_data_out: data_out=%h expected c3", data_out); end
    n_vec++; if (n_dv - dv0 != 1)   begin n_err++; $display("FAIL wr_dv_count: pulses=%0d expected 1", n_dv - dv0); end
  endtask

  task automatic test_addr_mismatch();
    int dv0 = n_dv;
    i2c_start();
    write_byte(8'h44, 1'b1, "mm_addr");
    check_state(4'd0, "mm_idle");
    write_byte(8'h11, 1'b1, "mm_data");
    i2c_stop();
    n_vec++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL mm_data_out: data_out=%h expected c3", data_out); end
    n_vec++; if (n_dv != dv0)        begin n_err++; $display("FAIL mm_dv_count: pulses=%0d expected 0", n_dv - dv0); end
  endtask

  task automatic test_read_nack();
    data_in = 8'hA5;
    i2c_start();
    write_byte(8'hB5, 1'b0, "rd_addr");
    read_byte(8'hA5, 1'b1, "rd_a5");
    check_state(4'd7, "rd_wait_stop");
    i2c_stop();
    check_state(4'd0, "rd_after_stop");
  endtask

  task automatic test_back_to_back_read();
    data_in = 8'h3C;
    i2c_start();
    write_byte(8'hB5, 1'b0, "rd2_addr");
    #Q; data_in = 8'h81;
    read_byte(8'h3C, 1'b0, "rd2_b1");
    check_state(4'd5, "rd2_reloaded");
    read_byte(8'h81, 1'b1, "rd2_b2");
    check_state(4'd7, "rd2_wait_stop");
    i2c_stop();
    check_state(4'd0, "rd2_after_stop");
  endtask

  task automatic test_repeated_start();
    int dv0 = n_dv;
    logic [3:0] part = 4'b1010;
    i2c_start();
    write_byte(8'hB4, 1'b0, "rs_addr1");
    for (int i = 3; i >= 0; i--) begin
      q_sda.push_back(1'b1);
      sclk_bit(part[i], "rs_partial");
    end
    i2c_start();
    check_state(4'd1, "rs_state_addr");
    write_byte(8'hB4, 1'b0, "rs_addr2");
    i2c_stop();
    check_state(4'd0, "rs_after_stop");
    n_vec++; if (n_dv != dv0)        begin n_err++; $display("FAIL rs_dv_count: pulses=%0d expected 0", n_dv - dv0); end
    n_vec++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL rs_data_out: data_out=%h expected c3", data_out); end
  endtask

  task automatic test_reset_mid_read();
    int dv0;
    logic [7:0] junk = 8'hB4;
    data_in = 8'h00;
    i2c_start();
    write_byte(8'hB5, 1'b0, "mr_addr");
    for (int i = 0; i < 3; i++) begin
      q_sda.push_back(1'b0);
      sclk_bit(1'b1, "mr_bits");
    end
    sda_in = 1'b1;
    #Q; sclk = 1'b1;
    #Q;
    n_vec++; if (sda_out !== 1'b0) begin n_err++; $display("FAIL mr_pre: sda_out=%b expected 0", sda_out); end
    @(negedge clk); #1; rst = 1'b0; #1;
    n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL mr_async_sda: sda_out=%b expected 1", sda_out); end
    check_state(4'd0, "mr_async_state");
    #30; rst = 1'b1;
    #Q; sclk = 1'b0; #Q;
    dv0 = n_dv;
    for (int i = 7; i >= 0; i--) begin
      q_sda.push_back(1'b1);
      sclk_bit(junk[i], "mr_noresp");
    end
    q_sda.push_back(1'b1);
    sclk_bit(1'b1, "mr_noresp_ack");
    check_state(4'd0, "mr_idle");
    n_vec++; if (n_dv != dv0) begin n_err++; $display("FAIL mr_dv_count: pulses=%0d expected 0", n_dv - dv0); end
    // Fresh transaction after recovery
    i2c_stop();
    i2c_start();
    write_byte(8'hB4, 1'b0, "mr_new_addr");
    q_byte.push_back(8'h5A);
    write_byte(8'h5A, 1'b0, "mr_new_data");
    i2c_stop();
    n_vec++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL mr_new_data_out: data_out=%h expected 5a", data_out); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read_nack();
    test_back_to_back_read();
    test_repeated_start();
    test_reset_mid_read();
    #200;
    n_vec++;
    if (q_byte.size() != 0 || q_sda.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d bytes and %0d bits left unconsumed", q_byte.size(), q_sda.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
